// File: rtl/rf_write_arbiter.sv
// Purpose: shares the RegFile write port between the CPU writeback (0) and host/debug (1), with a host lock that stalls the CPU.
// Latency: a request sampled at edge N yields gnt and rf_we during cycle N+1; the RegFile commits at edge N+1.
// Backpressure: req is held until gnt. A granted requester is masked for one cycle, so each side gets at most 1 write per 2 cycles.
module rf_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              cpu_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [CNT_W-1:0]  wr_cnt0,
  output logic [CNT_W-1:0]  wr_cnt1
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q;
  state_t            state_d;
  logic              last_q;
  logic              last_d;
  logic              last_eff;
  logic              elig0;
  logic              elig1;
  logic              win_vld;
  logic              win_sel;
  logic [ADDR_W-1:0] win_wa;
  logic [DATA_W-1:0] win_wd;

  // Next state, eligibility and round-robin selection from the inputs sampled this edge.
  always_comb begin
    state_d  = ST_ARB;
    last_eff = last_q;
    elig0    = 1'b0;
    elig1    = 1'b0;
    win_vld  = 1'b0;
    win_sel  = 1'b0;
    last_d   = last_q;
    win_wa   = wa0;
    win_wd   = wd0;

    if (lock1) begin
      state_d = ST_LOCK;
    end

    // Leaving LOCK hands priority back to the CPU, so a tie on the exit edge goes to 0.
    if (state_q == ST_LOCK) begin
      last_eff = 1'b1;
    end

    // The current-grant mask stops a requester that holds req through its grant from being written twice.
    elig0 = req0 & ~gnt0 & ~lock1;
    elig1 = req1 & ~gnt1;

    win_vld = elig0 | elig1;
    if (elig0 && elig1) begin
      win_sel = ~last_eff;
    end else begin
      win_sel = elig1;
    end

    if (win_vld) begin
      last_d = win_sel;
    end else begin
      last_d = last_eff;
    end

    if (win_sel) begin
      win_wa = wa1;
      win_wd = wd1;
    end
  end

  // State and round-robin pointer registers. After reset the pointer favours requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARB;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign cpu_stall = (state_q == ST_LOCK);

  // Registered grant pulses and RegFile write port. Address and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      gnt0  <= win_vld & ~win_sel;
      gnt1  <= win_vld & win_sel;
      rf_we <= win_vld;
      if (win_vld) begin
        rf_wa <= win_wa;
        rf_wd <= win_wd;
      end
    end
  end

  // Saturating per-requester write counters, stepped on each edge that raises a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt0 <= '0;
      wr_cnt1 <= '0;
    end else begin
      if (win_vld && !win_sel && (wr_cnt0 != CNT_MAX)) begin
        wr_cnt0 <= wr_cnt0 + CNT_ONE;
      end
      if (win_vld && win_sel && (wr_cnt1 != CNT_MAX)) begin
        wr_cnt1 <= wr_cnt1 + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose: randomized and directed stimulus for rf_write_arbiter, with a scoreboard fed by a behavioural model.
// Latency: the model predicts at edge N the write the DUT shows in cycle N+1; the monitor compares at the following negedge.
// Backpressure: none; the bench only drives inputs and observes the outputs.
module tb_rf_write_arbiter;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              req0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic              lock1;
  logic              gnt1;
  logic              cpu_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [CNT_W-1:0]  wr_cnt0;
  logic [CNT_W-1:0]  wr_cnt1;

  rf_write_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .wa0      (wa0),
    .wd0      (wd0),
    .gnt0     (gnt0),
    .req1     (req1),
    .wa1      (wa1),
    .wd1      (wd1),
    .lock1    (lock1),
    .gnt1     (gnt1),
    .cpu_stall(cpu_stall),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .wr_cnt0  (wr_cnt0),
    .wr_cnt1  (wr_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int who;
    int wa;
    int wd;
    int c0;
    int c1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 0;

  // Reference model state: who won the previous edge, round-robin preference, lock, counters, held write port.
  int   m_prev_who = -1;
  int   m_last     = 1;
  bit   m_lock     = 0;
  int   m_c0       = 0;
  int   m_c1       = 0;
  int   m_hold_wa  = 0;
  int   m_hold_wd  = 0;
  bit   m_c0_ok;
  bit   m_c1_ok;
  int   m_who;
  exp_t m_item;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Behavioural model: at each edge decide which requester, if any, wins the write port.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_prev_who = -1;
      m_last     = 1;
      m_lock     = 0;
      m_c0       = 0;
      m_c1       = 0;
      m_hold_wa  = 0;
      m_hold_wd  = 0;
    end else begin
      m_c0_ok = req0 && (m_prev_who != 0) && !lock1;
      m_c1_ok = req1 && (m_prev_who != 1);
      m_who   = -1;
      if (m_c0_ok && m_c1_ok) m_who = (m_lock || m_last == 1) ? 0 : 1;
      else if (m_c0_ok)       m_who = 0;
      else if (m_c1_ok)       m_who = 1;

      if (m_who == 0) m_c0 = (m_c0 < CNT_SAT) ? m_c0 + 1 : CNT_SAT;
      if (m_who == 1) m_c1 = (m_c1 < CNT_SAT) ? m_c1 + 1 : CNT_SAT;

      if (m_who >= 0) begin
        m_last      = m_who;
        m_hold_wa   = (m_who == 0) ? int'(wa0) : int'(wa1);
        m_hold_wd   = (m_who == 0) ? int'(wd0) : int'(wd1);
        m_item.who  = m_who;
        m_item.wa   = m_hold_wa;
        m_item.wd   = m_hold_wd;
        m_item.c0   = m_c0;
        m_item.c1   = m_c1;
        exp_q.push_back(m_item);
      end else if (m_lock) begin
        m_last = 1;
      end
      m_prev_who = m_who;
      m_lock     = lock1;
    end
  end

  // Monitor: every cycle, match whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_write");
        end else begin
          e = exp_q.pop_front();
          check("sb_gnt0", longint'(gnt0), longint'(e.who == 0));
          check("sb_gnt1", longint'(gnt1), longint'(e.who == 1));
          check("sb_rf_wa", longint'(rf_wa), longint'(e.wa));
          check("sb_rf_wd", longint'(rf_wd), longint'(e.wd));
          check("sb_wr_cnt0", longint'(wr_cnt0), longint'(e.c0));
          check("sb_wr_cnt1", longint'(wr_cnt1), longint'(e.c1));
        end
      end else begin
        check("idle_gnt", longint'(gnt0 | gnt1), 0);
        check("idle_hold_wa", longint'(rf_wa), longint'(m_hold_wa));
        check("idle_hold_wd", longint'(rf_wd), longint'(m_hold_wd));
        if (exp_q.size() != 0) begin
          fail("missing_write");
          void'(exp_q.pop_front());
        end
      end
      check("cpu_stall", longint'(cpu_stall), longint'(m_lock));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0  = 1'b0;
    req1  = 1'b0;
    lock1 = 1'b0;
    wa0   = '0;
    wa1   = '0;
    wd0   = '0;
    wd1   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int g0_seen;

    clear_inputs();
    reset = 1'b1;
    do_reset();
    mon_en = 1;

    // Reset then idle: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_idle_we", longint'(rf_we), 0);
      check("rst_idle_gnt", longint'({gnt1, gnt0}), 0);
      check("rst_idle_stall", longint'(cpu_stall), 0);
      check("rst_idle_wa_wd", longint'({rf_wa, rf_wd}), 0);
      check("rst_idle_cnt", longint'({wr_cnt1, wr_cnt0}), 0);
      tick();
    end

    // Single requester-0 write held for one cycle.
    do_reset();
    req0 = 1'b1; wa0 = 2'd2; wd0 = 8'h5A;
    tick();
    req0 = 1'b0;
    @(negedge clk);
    check("single_gnt0", longint'(gnt0), 1);
    check("single_we", longint'(rf_we), 1);
    check("single_wa", longint'(rf_wa), 2);
    check("single_wd", longint'(rf_wd), 'h5A);
    check("single_cnt0", longint'(wr_cnt0), 1);
    tick();
    @(negedge clk);
    check("single_no_second", longint'(rf_we), 0);

    // Both requesting for 8 edges: grants alternate starting with 0.
    do_reset();
    req0 = 1'b1; wa0 = 2'd1; wd0 = 8'h11;
    req1 = 1'b1; wa1 = 2'd3; wd1 = 8'h22;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      check("alt_gnt0", longint'(gnt0), longint'(i % 2 == 0));
      check("alt_wd", longint'(rf_wd), (i % 2 == 0) ? 'h11 : 'h22);
      if (i == 7) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    check("alt_cnt0", longint'(wr_cnt0), 4);
    check("alt_cnt1", longint'(wr_cnt1), 4);

    // Lock while req0 is held: CPU stalls, host still writes, CPU wins the exit tie.
    do_reset();
    req0 = 1'b1; wa0 = 2'd1; wd0 = 8'hA0;
    tick();
    lock1 = 1'b1; req1 = 1'b1; wa1 = 2'd3; wd1 = 8'hB0;
    tick();
    @(negedge clk);
    check("lock_stall", longint'(cpu_stall), 1);
    check("lock_gnt1", longint'(gnt1), 1);
    g0_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (gnt0) g0_seen++;
      check("lock_stall_hold", longint'(cpu_stall), 1);
    end
    check("lock_no_gnt0", g0_seen, 0);
    lock1 = 1'b0;
    tick();
    @(negedge clk);
    check("unlock_gnt0_first", longint'(gnt0), 1);
    check("unlock_stall", longint'(cpu_stall), 0);
    req0 = 1'b0;
    req1 = 1'b0;

    // 300 host writes: counter saturates and stays.
    do_reset();
    req1 = 1'b1;
    for (int i = 0; i < 600; i++) begin
      wa1 = ADDR_W'($urandom);
      wd1 = DATA_W'($urandom);
      tick();
    end
    @(negedge clk);
    check("sat_cnt1", longint'(wr_cnt1), CNT_SAT);
    repeat (4) tick();
    @(negedge clk);
    check("sat_cnt1_hold", longint'(wr_cnt1), CNT_SAT);
    req1 = 1'b0;

    // Reset on the edge that samples req1, taken from LOCK with nonzero counters.
    lock1 = 1'b1;
    tick();
    @(negedge clk);
    check("pre_rst_stall", longint'(cpu_stall), 1);
    req1 = 1'b1; wd1 = 8'h77; reset = 1'b1;
    tick();
    reset = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
    check("rst_mid_gnt1", longint'(gnt1), 0);
    check("rst_mid_we", longint'(rf_we), 0);
    check("rst_mid_stall", longint'(cpu_stall), 0);
    check("rst_mid_cnt", longint'({wr_cnt1, wr_cnt0}), 0);

    // Randomized traffic with occasional lock changes and resets.
    for (int i = 0; i < 3000; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) == 0);
      wa0  = ADDR_W'($urandom);
      wa1  = ADDR_W'($urandom);
      wd0  = DATA_W'($urandom);
      wd1  = DATA_W'($urandom);
      if ($urandom_range(0, 15) == 0) lock1 = ~lock1;
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    clear_inputs();
    reset = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single RegFile write port between two requesters: requester 0 (the CPU control unit's writeback) and requester 1 (the host/debug port).
- Fair round-robin arbitration with a registered req/gnt handshake.
- Requester 1 can take an exclusive lock that stalls the CPU.
- Sits between the control unit / debug port and the RegFile write inputs; keeps saturating per-requester write counters for debug.

Parameters:
- DATA_W, 8, RegFile data width.
- ADDR_W, 2, RegFile address width (4 registers).
- CNT_W, 8, width of each saturating write counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 (CPU writeback) write request.
- wa0  input  ADDR_W  requester 0 write address.
- wd0  input  DATA_W  requester 0 write data.
- gnt0  output  1  registered grant pulse to requester 0.
- req1  input  1  requester 1 (host/debug) write request.
- wa1  input  ADDR_W  requester 1 write address.
- wd1  input  DATA_W  requester 1 write data.
- lock1  input  1  requester 1 exclusive-access request.
- gnt1  output  1  registered grant pulse to requester 1.
- cpu_stall  output  1  high while in LOCK; the control unit must hold its state.
- rf_we  output  1  RegFile write enable.
- rf_wa  output  ADDR_W  RegFile write address.
- rf_wd  output  DATA_W  RegFile write data.
- wr_cnt0  output  CNT_W  writes granted to requester 0, saturating.
- wr_cnt1  output  CNT_W  writes granted to requester 1, saturating.

Behaviour:
- Reset (sync, active-high):
  - Outputs: gnt0=gnt1=0, rf_we=0, rf_wa=0, rf_wd=0, cpu_stall=0, wr_cnt0=wr_cnt1=0.
  - Internal: state=ARB, last=1, so req0 wins the first tie.
- Reset asserted mid-transfer: any in-flight write is dropped; rf_we=0 in the cycle after the reset edge.
- FSM states: ARB (normal sharing) and LOCK (requester 1 exclusive). At every edge: next state = LOCK if lock1=1, else ARB. cpu_stall is 1 exactly while state=LOCK.
- Eligibility, evaluated at each edge from sampled inputs:
  - e0 = req0 & ~gnt0 & ~lock1.
  - e1 = req1 & ~gnt1.
  - The current-grant mask means a requester holding req across its grant cycle is not double-written. Per-requester throughput is therefore at most 1 write per 2 cycles.
- Selection:
  - Only e0: pick 0. Only e1: pick 1.
  - Both: pick the requester that is not `last`.
  - Neither: no grant.
  - The winner is recorded in `last`.
- Grant, at the same edge as selection:
  - gnt_i <= 1 for the winner (the other gnt <= 0).
  - rf_we <= 1; rf_wa/rf_wd <= the winner's wa_i/wd_i, captured at that edge.
  - No winner: gnt0=gnt1=rf_we=0; rf_wa/rf_wd hold their previous values.
- Latency: req sampled at edge N produces gnt and rf_we high during cycle N+1. The RegFile commits at edge N+1. The requester may change wa/wd or drop req after observing gnt.
- Handshake rule: a requester holds req, wa and wd stable until it sees its gnt. Deasserting req before the grant cancels the request with no write.
- Lock entry: lock1 sampled high blocks req0 at that same edge. A gnt0 already in flight completes normally. cpu_stall rises in the following cycle.
- Lock exit: lock1 sampled low → ARB and last <= 1, so a pending req0 wins any tie on the next edge.
- Counters: wr_cnt_i increments at each edge that sets gnt_i. It holds at 2^CNT_W-1 (255) and does not wrap.
- Addresses and data pass through unmodified; there is no width conversion or arithmetic on the data path.

Test Plan:
- Reset then idle → all outputs 0 for 5 cycles; wr_cnt0=wr_cnt1=0.
- req0=1, wa0=2, wd0=0x5A held 1 cycle → next cycle gnt0=1, rf_we=1, rf_wa=2, rf_wd=0x5A; wr_cnt0=1; no second write.
- req0 and req1 held high for 8 cycles (wd0=0x11, wd1=0x22) → grants alternate 0,1,0,1 starting with 0; rf_wd alternates 0x11/0x22; wr_cnt0=wr_cnt1=4.
- lock1 asserted while req0 is held:
  - cpu_stall=1 from the next cycle; no gnt0 during LOCK; req1 writes still granted.
  - On lock1 drop with both requesting, gnt0 comes first.
- 300 consecutive requester-1 writes → wr_cnt1 saturates at 255 and stays there.
- reset pulsed in the cycle where req1 is sampled → no gnt1, rf_we=0, state ARB, counters 0.
